// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//
// Sequences a 2-way set-associative data cache (64 sets, 64-bit lines,
// 11-bit tag / 6-bit index / 1-bit word offset) between the MEM-stage
// load/store port and the SRAM controller.
// Policy: read-allocate, write-through, write-no-allocate; a store that
// hits invalidates the matching line. Keeps saturating hit/miss counters.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   mem_r_en, mem_w_en  load / store request from MEM stage (held until ready)
//   address, wdata      CPU byte address and store data
//   rdata, ready        load data and request-complete / pipeline advance
//   cache_*             cache address, read data, hit flag and strobes
//   sram_*              SRAM controller address, data and handshake
//   hit_count           saturating count of load hits
//   miss_count          saturating count of load misses
// ---------------------------------------------------------------------------
module cache_controller #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic [31:0]      address,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic [17:0]      cache_address,
    input  logic [31:0]      cache_read_data,
    input  logic             cache_hit,
    output logic             cache_r_en,
    output logic             cache_lru_update,
    output logic             cache_write_en,
    output logic [63:0]      cache_write_data,
    output logic             cache_invalidate,
    output logic [31:0]      sram_address,
    output logic [31:0]      sram_wdata,
    output logic             sram_r_en,
    output logic             sram_w_en,
    input  logic [63:0]      sram_rdata,
    input  logic             sram_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_off;
    logic [31:0] cur_addr;

    logic        is_store;
    logic        is_load;
    logic        accept;
    logic        hit_evt;
    logic        miss_evt;

    assign addr_off = address - 32'(BASE_ADDR);

    // A simultaneous load+store request is handled as a store only.
    assign is_store = mem_w_en;
    assign is_load  = mem_r_en & ~mem_w_en;

    // IDLE looks straight through to the live address so a read hit can
    // complete in the same cycle; busy states work from the latched copy.
    assign cur_addr = (state == IDLE) ? addr_off : addr_q;

    assign cache_address    = cur_addr[19:2];
    assign sram_address     = (state == READ_MISS) ? {cur_addr[31:3], 3'b000} : cur_addr;
    assign sram_wdata       = wdata_q;
    assign cache_write_data = sram_rdata;
    // The cache refreshes LRU on its own during fills and on MEM_R_EN hits.
    assign cache_lru_update = 1'b0;

    always_comb begin
        state_next       = state;
        ready            = 1'b1;
        rdata            = '0;
        cache_r_en       = 1'b0;
        cache_write_en   = 1'b0;
        cache_invalidate = 1'b0;
        sram_r_en        = 1'b0;
        sram_w_en        = 1'b0;
        accept           = 1'b0;
        hit_evt          = 1'b0;
        miss_evt         = 1'b0;

        case (state)
            IDLE: begin
                if (is_store) begin
                    cache_invalidate = cache_hit;
                    ready            = 1'b0;
                    accept           = 1'b1;
                    state_next       = WRITE;
                end else if (is_load) begin
                    if (cache_hit) begin
                        cache_r_en = 1'b1;
                        rdata      = cache_read_data;
                        hit_evt    = 1'b1;
                    end else begin
                        ready      = 1'b0;
                        miss_evt   = 1'b1;
                        accept     = 1'b1;
                        state_next = READ_MISS;
                    end
                end
            end
            READ_MISS: begin
                sram_r_en = 1'b1;
                ready     = 1'b0;
                if (sram_ready) begin
                    cache_write_en = 1'b1;
                    ready          = 1'b1;
                    rdata          = addr_q[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                    state_next     = IDLE;
                end
            end
            WRITE: begin
                sram_w_en = 1'b1;
                ready     = 1'b0;
                if (sram_ready) begin
                    ready      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // While reset is held the pipeline sees an idle, ready controller,
        // even before the state register has been cleared by the clock edge.
        if (!rst) begin
            state_next       = IDLE;
            ready            = 1'b1;
            rdata            = '0;
            cache_r_en       = 1'b0;
            cache_write_en   = 1'b0;
            cache_invalidate = 1'b0;
            sram_r_en        = 1'b0;
            sram_w_en        = 1'b0;
            accept           = 1'b0;
            hit_evt          = 1'b0;
            miss_evt         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= addr_off;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_evt && (hit_count != '1)) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss_evt && (miss_count != '1)) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] cache_address;
    logic [31:0] cache_read_data;
    logic        cache_hit;
    logic        cache_r_en;
    logic        cache_lru_update;
    logic        cache_write_en;
    logic [63:0] cache_write_data;
    logic        cache_invalidate;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks;
    int failures;

    cache_controller #(
        .BASE_ADDR(1024),
        .CNT_W    (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_r_en        (mem_r_en),
        .mem_w_en        (mem_w_en),
        .address         (address),
        .wdata           (wdata),
        .rdata           (rdata),
        .ready           (ready),
        .cache_address   (cache_address),
        .cache_read_data (cache_read_data),
        .cache_hit       (cache_hit),
        .cache_r_en      (cache_r_en),
        .cache_lru_update(cache_lru_update),
        .cache_write_en  (cache_write_en),
        .cache_write_data(cache_write_data),
        .cache_invalidate(cache_invalidate),
        .sram_address    (sram_address),
        .sram_wdata      (sram_wdata),
        .sram_r_en       (sram_r_en),
        .sram_w_en       (sram_w_en),
        .sram_rdata      (sram_rdata),
        .sram_ready      (sram_ready),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        mem_r_en        = 1'b0;
        mem_w_en        = 1'b0;
        cache_hit       = 1'b0;
        cache_read_data = '0;
        sram_ready      = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic        hit;
        logic [31:0] crd;
        logic        exp_ready;
        logic        exp_r_en;
        logic        exp_inv;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic [17:0] exp_caddr;
    } vec_t;

    vec_t vecs[7];

    int low_cnt;
    int fills;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        address  = '0;
        wdata    = '0;
        sram_rdata = '0;
        clear_req();

        // IDLE response table: requests are withdrawn before the next edge,
        // so each row sees the controller in IDLE.
        vecs[0] = '{"idle",        0, 0, 32'h0000_0400, 0, 32'h0,         1, 0, 0, 0, 32'h0,         18'h00000};
        vecs[1] = '{"ld_hit",      1, 0, 32'h0000_040C, 1, 32'hCAFE_F00D, 1, 1, 0, 1, 32'hCAFE_F00D, 18'h00003};
        vecs[2] = '{"ld_miss",     1, 0, 32'h0000_1404, 0, 32'h1234_5678, 0, 0, 0, 0, 32'h0,         18'h00401};
        vecs[3] = '{"st_hit",      0, 1, 32'h0000_0800, 1, 32'h0,         0, 0, 1, 0, 32'h0,         18'h00100};
        vecs[4] = '{"st_miss",     0, 1, 32'h0000_0800, 0, 32'h0,         0, 0, 0, 0, 32'h0,         18'h00100};
        vecs[5] = '{"both_hit",    1, 1, 32'h0000_0404, 1, 32'h5A5A_5A5A, 0, 0, 1, 0, 32'h0,         18'h00001};
        vecs[6] = '{"below_base",  1, 0, 32'h0000_03FC, 1, 32'h0000_0001, 1, 1, 0, 1, 32'h0000_0001, 18'h3FFFF};

        // Reset
        tick();
        tick();
        chk("rst_ready", ready, 1);
        chk("rst_sram_r_en", sram_r_en, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_lru", cache_lru_update, 0);
        rst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            mem_r_en        = vecs[i].r;
            mem_w_en        = vecs[i].w;
            address         = vecs[i].addr;
            cache_hit       = vecs[i].hit;
            cache_read_data = vecs[i].crd;
            #1;
            chk({vecs[i].name, "_ready"}, ready, vecs[i].exp_ready);
            chk({vecs[i].name, "_cache_r_en"}, cache_r_en, vecs[i].exp_r_en);
            chk({vecs[i].name, "_inv"}, cache_invalidate, vecs[i].exp_inv);
            chk({vecs[i].name, "_caddr"}, cache_address, vecs[i].exp_caddr);
            chk({vecs[i].name, "_fill"}, cache_write_en, 0);
            chk({vecs[i].name, "_sram_r"}, sram_r_en, 0);
            chk({vecs[i].name, "_sram_w"}, sram_w_en, 0);
            if (vecs[i].chk_rdata) chk({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            clear_req();
            tick();
        end
        chk("table_hit_count", hit_count, 0);
        chk("table_miss_count", miss_count, 0);

        // Cold load miss 0x400, SRAM latency 5
        sram_rdata = 64'h1111_2222_3333_4444;
        mem_r_en   = 1'b1;
        address    = 32'h0000_0400;
        #1;
        low_cnt = (ready == 1'b0) ? 1 : 0;
        fills   = 0;
        chk("miss_c0_sram_r", sram_r_en, 0);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            if (cyc == 6) sram_ready = 1'b1;
            #1;
            if (ready == 1'b0) low_cnt++;
            if (cache_write_en) fills++;
            if (cyc == 1) begin
                chk("miss_sram_r_en", sram_r_en, 1);
                chk("miss_count_1", miss_count, 1);
                chk("miss_sram_addr", sram_address, 32'h0);
            end
        end
        chk("miss_ready", ready, 1);
        chk("miss_rdata", rdata, 32'h3333_4444);
        chk("miss_fill_data", cache_write_data, 64'h1111_2222_3333_4444);
        chk("miss_sram_r_on_ready", sram_r_en, 1);
        chk("miss_low_cycles", low_cnt, 6);
        chk("miss_fill_pulses", fills, 1);
        tick();
        clear_req();
        #1;
        chk("miss_after_sram_r", sram_r_en, 0);
        chk("miss_after_fill", cache_write_en, 0);
        chk("miss_after_ready", ready, 1);

        // Load hit 0x404 -> upper word of the filled line
        mem_r_en        = 1'b1;
        address         = 32'h0000_0404;
        cache_hit       = 1'b1;
        cache_read_data = 32'h1111_2222;
        #1;
        chk("hit_ready", ready, 1);
        chk("hit_rdata", rdata, 32'h1111_2222);
        chk("hit_r_en", cache_r_en, 1);
        chk("hit_caddr", cache_address, 18'h00001);
        tick();
        clear_req();
        #1;
        chk("hit_count_1", hit_count, 1);

        // Store 0x400 hit: invalidate, write-through
        mem_w_en  = 1'b1;
        address   = 32'h0000_0400;
        wdata     = 32'hDEAD_BEEF;
        cache_hit = 1'b1;
        #1;
        chk("st_inv", cache_invalidate, 1);
        chk("st_ready0", ready, 0);
        chk("st_r_en", cache_r_en, 0);
        tick();
        address = 32'h1234_5678;
        wdata   = 32'h0;
        #1;
        chk("st_inv_once", cache_invalidate, 0);
        chk("st_sram_w", sram_w_en, 1);
        chk("st_sram_addr", sram_address, 32'h0);
        chk("st_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
        chk("st_wait_ready", ready, 0);
        tick();
        tick();
        sram_ready = 1'b1;
        #1;
        chk("st_done_ready", ready, 1);
        chk("st_no_fill", cache_write_en, 0);
        chk("st_sram_w_last", sram_w_en, 1);
        tick();
        clear_req();
        #1;
        chk("st_after_w", sram_w_en, 0);
        chk("st_hit_count", hit_count, 1);
        chk("st_miss_count", miss_count, 1);

        // Next load 0x400 misses
        mem_r_en = 1'b1;
        address  = 32'h0000_0400;
        #1;
        chk("reload_ready", ready, 0);
        tick();
        sram_ready = 1'b1;
        #1;
        chk("reload_done", ready, 1);
        chk("reload_rdata", rdata, 32'h3333_4444);
        tick();
        clear_req();

        // Miss on upper word 0x40C: line-aligned SRAM address, high word
        sram_rdata = 64'hAAAA_0000_BBBB_1111;
        mem_r_en   = 1'b1;
        address    = 32'h0000_040C;
        tick();
        #1;
        chk("hi_sram_addr", sram_address, 32'h8);
        sram_ready = 1'b1;
        #1;
        chk("hi_rdata", rdata, 32'hAAAA_0000);
        tick();
        clear_req();
        #1;
        chk("hi_miss_count", miss_count, 3);

        // Load and store together: store path only
        mem_r_en = 1'b1;
        mem_w_en = 1'b1;
        address  = 32'h0000_0500;
        wdata    = 32'h0000_5555;
        #1;
        chk("both_ready0", ready, 0);
        chk("both_r_en", cache_r_en, 0);
        tick();
        sram_ready = 1'b1;
        #1;
        chk("both_sram_w", sram_w_en, 1);
        chk("both_sram_r", sram_r_en, 0);
        chk("both_sram_addr", sram_address, 32'h100);
        chk("both_sram_wdata", sram_wdata, 32'h0000_5555);
        chk("both_done", ready, 1);
        tick();
        clear_req();
        #1;
        chk("both_hit_count", hit_count, 1);
        chk("both_miss_count", miss_count, 3);

        // sram_ready while idle is ignored
        sram_ready = 1'b1;
        #1;
        chk("idle_sr_fill", cache_write_en, 0);
        tick();
        sram_ready = 1'b0;
        #1;
        chk("idle_sr_sram_r", sram_r_en, 0);
        chk("idle_sr_sram_w", sram_w_en, 0);

        // Reset held two cycles in the middle of a read miss
        mem_r_en = 1'b1;
        address  = 32'h0000_0600;
        tick();
        #1;
        chk("rstm_busy", sram_r_en, 1);
        rst        = 1'b0;
        sram_ready = 1'b1;
        #1;
        chk("rstm_ready", ready, 1);
        chk("rstm_sram_r", sram_r_en, 0);
        chk("rstm_fill", cache_write_en, 0);
        tick();
        clear_req();
        #1;
        chk("rstm_fill2", cache_write_en, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("rstm_idle_ready", ready, 1);
        chk("rstm_idle_sram_r", sram_r_en, 0);
        chk("rstm_hit_count", hit_count, 0);
        chk("rstm_miss_count", miss_count, 0);

        // Hit counter saturation
        mem_r_en        = 1'b1;
        address         = 32'h0000_0400;
        cache_hit       = 1'b1;
        cache_read_data = 32'h0;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", hit_count, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_ffff", hit_count, 16'hFFFF);
        clear_req();
        tick();
        chk("sat_hold", hit_count, 16'hFFFF);
        chk("sat_miss", miss_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequences the 2-way set-associative data cache (64 sets, 64-bit lines, 11-bit tag / 6-bit index / 1-bit word offset) between the MEM-stage load/store port and the SRAM controller.
- Policy: read-allocate, write-through, write-no-allocate; a store that hits invalidates the matching line.
- Drives the cache's LRU_update/invalidate/writeEn/MEM_R_EN strobes and stalls the pipeline via ready.
- Keeps saturating hit/miss counters for performance measurement.

Parameters:
- BASE_ADDR, 1024, byte address subtracted from the CPU address before indexing cache/SRAM.
- CNT_W, 16, width of hit/miss counters.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (state cleared on rising clk edge while rst==0).
- mem_r_en  input  1  load request from MEM stage, held until ready.
- mem_w_en  input  1  store request from MEM stage, held until ready.
- address  input  32  CPU byte address.
- wdata  input  32  store data.
- rdata  output  32  load data, valid when ready && load.
- ready  output  1  request complete / pipeline may advance.
- cache_address  output  18  {tag,index,offset} = (addr-BASE_ADDR)[19:2].
- cache_read_data  input  32  word from cache (valid on hit).
- cache_hit  input  1  cache hit flag for cache_address.
- cache_r_en  output  1  cache MEM_R_EN (LRU touch on read hit).
- cache_lru_update  output  1  cache LRU_update.
- cache_write_en  output  1  line fill strobe.
- cache_write_data  output  64  fill line.
- cache_invalidate  output  1  invalidate on store hit.
- sram_address  output  32  (addr-BASE_ADDR), low 3 bits forced 0 for reads.
- sram_wdata  output  32  store data to SRAM.
- sram_r_en  output  1  SRAM line read request.
- sram_w_en  output  1  SRAM word write request.
- sram_rdata  input  64  line from SRAM, valid with sram_ready.
- sram_ready  input  1  SRAM op complete (one-cycle pulse).
- hit_count  output  CNT_W  load hits, saturating.
- miss_count  output  CNT_W  load misses, saturating.

Behaviour:
- States: IDLE, READ_MISS, WRITE. Reset → IDLE, counters 0; during reset all strobes 0, ready=1. Reset mid-operation aborts to IDLE with no cache write; SRAM controller is reset by the same rst.
- Acceptance in IDLE latches address/wdata into registers; non-IDLE states use latched values only.
- mem_r_en && mem_w_en together: treated as a store (load ignored).
- IDLE, no request: ready=1, all strobes 0.
- IDLE, load, cache_hit=1: same-cycle completion: ready=1, rdata=cache_read_data, cache_r_en=1, hit_count+1. Stay IDLE.
- IDLE, load, cache_hit=0: ready=0, go READ_MISS, miss_count+1.
- READ_MISS: sram_r_en=1, ready=0 until sram_ready. On sram_ready cycle: cache_write_en=1, cache_write_data=sram_rdata, rdata=offset? sram_rdata[63:32] : sram_rdata[31:0], ready=1, → IDLE. sram_r_en drops the cycle after sram_ready.
- IDLE, store: cache_invalidate=cache_hit (one cycle, IDLE cycle only), ready=0, → WRITE.
- WRITE: sram_w_en=1, sram_wdata=latched wdata; on sram_ready: ready=1, → IDLE. No cache fill on store.
- Latency: read hit 0 extra cycles; read miss 1 + SRAM latency; store 1 + SRAM latency.
- Strobes mutually exclusive per cycle: at most one of cache_write_en, cache_invalidate, cache_r_en.
- cache_lru_update: pulsed with cache_write_en is NOT done (the cache updates LRU on fill itself); held 0 except for a read hit when cache_r_en is not used (never in this design — tie-off 0 reserved).
- Counters saturate at 2^CNT_W-1; no wrap.
- sram_ready outside READ_MISS/WRITE ignored.

Test Plan:
- Reset held low 2 cycles mid READ_MISS -> state IDLE, sram_r_en=0, cache_write_en never asserted, counters 0.
- Load address 0x400 (cache cold, SRAM latency 5, sram_rdata=0x11112222_33334444) -> ready low 6 cycles, fill strobe 1 cycle, rdata=0x33334444, miss_count=1.
- Repeat load 0x404 -> same-cycle ready, rdata=0x11112222, cache_r_en=1, hit_count=1.
- Store 0x400 data 0xDEADBEEF after fill -> cache_invalidate 1 cycle, sram_w_en until sram_ready, sram_address=0, next load 0x400 misses.
- mem_r_en and mem_w_en both 1 -> store path taken, no SRAM read, no counter change.
- Force hit_count to 0xFFFF via 65535+ hits -> stays 0xFFFF.
